ex_mem_pipe_reg: RTL and testbench
==================================

// Module: ex_mem_pipe_reg
// PURPOSE
//  Clocked, parametrised EX->MEM pipeline register; successor to the combinational EX pass-through.
//  Carries WB/MEM control, destination reg, ALU result and store data.
//  Adds a valid/ready handshake, a 1-entry skid buffer, flush, and a stall-cycle counter.
//  Sits between the ALU stage and the data-memory stage of the core.
// PARAMETERS
//  WB_W      2   width of WB control field
//  MEM_W     3   width of MEM control field
//  RD_W      5   destination register index width
//  XLEN      32  width of ALU result and store data
//  CNT_W     16  width of saturating stall counter
// PORTS
//  clk            in   1      clock, all state on rising edge
//  reset          in   1      synchronous, active-high reset
//  flush          in   1      kill all held entries (branch/exception)
//  in_valid       in   1      EX presents a valid instruction
//  in_ready       out  1      register can accept this cycle
//  WB_in          in   WB_W   WB control from EX
//  MEM_in         in   MEM_W  MEM control from EX
//  RD_in          in   RD_W   destination register from EX
//  ALU_in         in   XLEN   ALU result
//  WriteData_in   in   XLEN   store data
//  out_valid      out  1      MEM-side entry valid
//  out_ready      in   1      MEM stage consumes this cycle
//  WB_out         out  WB_W   WB control; forced 0 when out_valid=0
//  MEM_out        out  MEM_W  MEM control; forced 0 when out_valid=0
//  RD_out         out  RD_W   destination register
//  ALU_out        out  XLEN   ALU result
//  WriteData_out  out  XLEN   store data
//  stall_cnt      out  CNT_W  cycles with out_valid=1 && out_ready=0, saturating
// BEHAVIOUR
//  - Two entries: MAIN (drives outputs) and SKID. Each entry has a valid bit.
//  - Reset (sync, highest priority): both valid bits 0, all payload regs 0, stall_cnt 0.
//    All outputs read 0 the cycle after reset is sampled. in_ready=1 after reset.
//  - in_ready = !skid_valid. It is a registered function of state with no comb path from out_ready.
//  - Accept: in_valid && in_ready. Consume: out_valid && out_ready. out_valid = main_valid.
//  - Latency 1 cycle: data accepted at edge N appears on outputs after edge N when MAIN is free or consumed.
//  - Per edge, with no flush:
//      main free or consumed, skid empty: MAIN <= input if accepted, else main_valid <= 0.
//      main free or consumed, skid full:  MAIN <= SKID, skid_valid <= 0; no accept (in_ready=0).
//      main held (valid, !out_ready), accept: SKID <= input, skid_valid <= 1.
//      main held, no accept: hold.
//  - Payload regs load only on accept/move. Otherwise they hold; no toggling on bubbles.
//  - WB_out/MEM_out are gated by out_valid so bubbles never write the regfile or memory.
//    RD/ALU/WriteData outputs are not gated.
//  - flush: both valid bits <= 0 at the edge, and the same-cycle input is dropped.
//    Payload is not cleared. Flush beats accept and consume. stall_cnt is unaffected.
//  - reset asserted mid-stall or with skid full: everything is cleared. reset beats flush.
//  - stall_cnt increments by 1 each cycle with out_valid && !out_ready.
//    It saturates at 2**CNT_W-1 and never wraps. It clears only on reset.
//  - Ordering: entries leave in arrival order. No entry is duplicated or lost except by flush.
// TESTING
//  T1 reset: assert reset 2 cycles with in_valid=1
//     -> out_valid=0, all outputs 0, stall_cnt=0, in_ready=1.
//  T2 streaming: out_ready=1, push ALU_in=1,2,3 on consecutive cycles
//     -> ALU_out=1,2,3 one cycle later each, back-to-back, in_ready stays 1.
//  T3 skid: hold out_ready=0, push A=0x10 then B=0x20
//     -> out_valid=1 with A, in_ready=0 after B. Release out_ready
//     -> A then B on consecutive cycles, in_ready=1 after B leaves.
//  T4 flush: with MAIN and SKID full, assert flush together with in_valid (C=0x30)
//     -> next cycle out_valid=0, WB_out=0, MEM_out=0, in_ready=1, C never appears.
//  T5 stall counter: CNT_W=4, hold one entry with out_ready=0 for 20 cycles
//     -> stall_cnt=15 and it holds; mid-run reset -> stall_cnt=0.
//  T6 bubble gating: in_valid=0 with WB_in=2'b11 and MEM_in=3'b111
//     -> WB_out=0 and MEM_out=0 every cycle. Random valid/ready scoreboard over 10k cycles: no loss, no reorder.

Source files
------------

// File: rtl/ex_mem_pipe_reg_if.sv
// EX->MEM handshake and payload bundle: the EX side drives the *_in fields,
// the MEM side drives out_ready, and the pipeline register drives everything else.
interface ex_mem_pipe_reg_if #(
  parameter int unsigned WB_W  = 2,
  parameter int unsigned MEM_W = 3,
  parameter int unsigned RD_W  = 5,
  parameter int unsigned XLEN  = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WB_W-1:0]  WB_in;
  logic [MEM_W-1:0] MEM_in;
  logic [RD_W-1:0]  RD_in;
  logic [XLEN-1:0]  ALU_in;
  logic [XLEN-1:0]  WriteData_in;

  logic             out_valid;
  logic             out_ready;
  logic [WB_W-1:0]  WB_out;
  logic [MEM_W-1:0] MEM_out;
  logic [RD_W-1:0]  RD_out;
  logic [XLEN-1:0]  ALU_out;
  logic [XLEN-1:0]  WriteData_out;

  // Environment side: EX producer plus MEM consumer.
  modport master (
    output in_valid, WB_in, MEM_in, RD_in, ALU_in, WriteData_in, out_ready,
    input  in_ready, out_valid, WB_out, MEM_out, RD_out, ALU_out, WriteData_out
  );

  // Pipeline-register side.
  modport slave (
    input  in_valid, WB_in, MEM_in, RD_in, ALU_in, WriteData_in, out_ready,
    output in_ready, out_valid, WB_out, MEM_out, RD_out, ALU_out, WriteData_out
  );
endinterface

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register: one-cycle latency, valid/ready handshake,
// one-entry skid buffer so in_ready never depends combinationally on out_ready,
// flush of all held entries, and a saturating stall-cycle counter.
module ex_mem_pipe_reg #(
  parameter int unsigned WB_W  = 2,
  parameter int unsigned MEM_W = 3,
  parameter int unsigned RD_W  = 5,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  ex_mem_pipe_reg_if.slave bus,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [WB_W-1:0]  wb;
    logic [MEM_W-1:0] mem;
    logic [RD_W-1:0]  rd;
    logic [XLEN-1:0]  alu;
    logic [XLEN-1:0]  wdata;
  } entry_t;

  entry_t main_q;
  entry_t skid_q;
  entry_t in_entry;
  logic   main_valid;
  logic   skid_valid;
  logic   main_free;
  logic   accept;
  logic   stall_sat;

  // Pack the EX-side fields into one entry.
  always_comb begin
    in_entry       = '0;
    in_entry.wb    = bus.WB_in;
    in_entry.mem   = bus.MEM_in;
    in_entry.rd    = bus.RD_in;
    in_entry.alu   = bus.ALU_in;
    in_entry.wdata = bus.WriteData_in;
  end

  // MAIN can take a new entry when empty or being consumed this cycle.
  assign main_free = !main_valid || bus.out_ready;
  assign accept    = bus.in_valid && !skid_valid;
  assign stall_sat = &stall_cnt;

  // Skid-empty ready comes straight from a flop, so no out_ready->in_ready path.
  assign bus.in_ready      = !skid_valid;
  assign bus.out_valid     = main_valid;
  // Control fields are zeroed on bubbles so nothing downstream writes.
  assign bus.WB_out        = main_valid ? main_q.wb  : '0;
  assign bus.MEM_out       = main_valid ? main_q.mem : '0;
  assign bus.RD_out        = main_q.rd;
  assign bus.ALU_out       = main_q.alu;
  assign bus.WriteData_out = main_q.wdata;

  // MAIN/SKID entry movement; payload only loads on accept or skid->main move.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_q     <= in_entry;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_q     <= in_entry;
      skid_valid <= 1'b1;
    end
  end

  // Saturating count of cycles where MEM holds off a valid entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (main_valid && !bus.out_ready && !stall_sat) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Self-checking bench for ex_mem_pipe_reg: directed scenarios plus a long
// randomized run, all checked against a FIFO-of-entries reference model.
module tb_ex_mem_pipe_reg;

  localparam int unsigned WB_W    = 2;
  localparam int unsigned MEM_W   = 3;
  localparam int unsigned RD_W    = 5;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
  localparam int unsigned OW      = 2 + WB_W + MEM_W + RD_W + 2 * XLEN + CNT_W;

  typedef struct packed {
    logic [WB_W-1:0]  wb;
    logic [MEM_W-1:0] mem;
    logic [RD_W-1:0]  rd;
    logic [XLEN-1:0]  alu;
    logic [XLEN-1:0]  wd;
  } ent_t;

  logic             clk;
  logic             reset;
  logic             flush;
  logic [CNT_W-1:0] stall_cnt;

  ex_mem_pipe_reg_if #(.WB_W(WB_W), .MEM_W(MEM_W), .RD_W(RD_W), .XLEN(XLEN)) bus ();

  ex_mem_pipe_reg #(
    .WB_W(WB_W), .MEM_W(MEM_W), .RD_W(RD_W), .XLEN(XLEN), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .bus(bus),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: ordered list of held entries (at most two), the payload
  // last presented at the head, and the stall count.
  ent_t q[$];
  ent_t shown;
  int   m_cnt;

  function automatic ent_t cur_in();
    return {bus.WB_in, bus.MEM_in, bus.RD_in, bus.ALU_in, bus.WriteData_in};
  endfunction

  function automatic logic [OW-1:0] m_out();
    logic v;
    v = (q.size() > 0);
    return {v, (q.size() < 2), v ? shown.wb : WB_W'(0), v ? shown.mem : MEM_W'(0),
            shown.rd, shown.alu, shown.wd, CNT_W'(m_cnt)};
  endfunction

  function automatic logic [OW-1:0] dut_out();
    return {bus.out_valid, bus.in_ready, bus.WB_out, bus.MEM_out, bus.RD_out,
            bus.ALU_out, bus.WriteData_out, stall_cnt};
  endfunction

  // Advance the model by the inputs currently applied, then clock the DUT.
  task automatic tick();
    int sz;
    bit acc;
    sz  = q.size();
    acc = bus.in_valid && (sz < 2);
    if (reset) begin
      q.delete();
      shown = '0;
      m_cnt = 0;
    end else begin
      if (sz > 0 && !bus.out_ready) m_cnt = (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
      if (flush) begin
        q.delete();
      end else begin
        if (sz > 0 && bus.out_ready) void'(q.pop_front());
        if (acc) q.push_back(cur_in());
      end
      if (q.size() > 0) shown = q[0];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [XLEN-1:0] alu);
    bus.in_valid     = v;
    bus.ALU_in       = alu;
    bus.WB_in        = WB_W'($urandom);
    bus.MEM_in       = MEM_W'($urandom);
    bus.RD_in        = RD_W'($urandom);
    bus.WriteData_in = XLEN'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 32'hdead_beef);
    bus.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    drive(1'b0, '0);
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0h exp=0", bus.out_valid); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%0h exp=1", bus.in_ready); else n_pass++;
    n_total++; if (bus.WB_out !== '0) $display("FAIL reset_wb got=%0h exp=0", bus.WB_out); else n_pass++;
    n_total++; if (bus.MEM_out !== '0) $display("FAIL reset_mem got=%0h exp=0", bus.MEM_out); else n_pass++;
    n_total++; if (bus.RD_out !== '0) $display("FAIL reset_rd got=%0h exp=0", bus.RD_out); else n_pass++;
    n_total++; if (bus.ALU_out !== '0) $display("FAIL reset_alu got=%0h exp=0", bus.ALU_out); else n_pass++;
    n_total++; if (bus.WriteData_out !== '0) $display("FAIL reset_wdata got=%0h exp=0", bus.WriteData_out); else n_pass++;
    n_total++; if (stall_cnt !== '0) $display("FAIL reset_stall_cnt got=%0h exp=0", stall_cnt); else n_pass++;
  endtask

  task automatic test_streaming();
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, XLEN'(i));
      tick();
      n_total++; if (bus.ALU_out !== XLEN'(i) || bus.out_valid !== 1'b1)
        $display("FAIL stream_data got=%0h/%0h exp=%0h/1", bus.ALU_out, bus.out_valid, i); else n_pass++;
      n_total++; if (bus.in_ready !== 1'b1) $display("FAIL stream_in_ready got=%0h exp=1", bus.in_ready); else n_pass++;
    end
    drive(1'b0, '0);
    tick();
    n_total++; if (bus.out_valid !== 1'b0 || bus.ALU_out !== XLEN'(3))
      $display("FAIL stream_drain got=%0h/%0h exp=0/3", bus.out_valid, bus.ALU_out); else n_pass++;
  endtask

  task automatic test_skid();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h10);
    tick();
    n_total++; if (bus.out_valid !== 1'b1 || bus.ALU_out !== 32'h10 || bus.in_ready !== 1'b1)
      $display("FAIL skid_a got=%0h/%0h/%0h exp=1/10/1", bus.out_valid, bus.ALU_out, bus.in_ready); else n_pass++;
    drive(1'b1, 32'h20);
    tick();
    n_total++; if (bus.in_ready !== 1'b0 || bus.ALU_out !== 32'h10)
      $display("FAIL skid_full got=%0h/%0h exp=0/10", bus.in_ready, bus.ALU_out); else n_pass++;
    drive(1'b0, '0);
    tick();
    n_total++; if (dut_out() !== m_out()) $display("FAIL skid_hold got=%0h exp=%0h", dut_out(), m_out()); else n_pass++;
    bus.out_ready = 1'b1;
    tick();
    n_total++; if (bus.out_valid !== 1'b1 || bus.ALU_out !== 32'h20)
      $display("FAIL skid_b got=%0h/%0h exp=1/20", bus.out_valid, bus.ALU_out); else n_pass++;
    tick();
    n_total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL skid_empty got=%0h/%0h exp=0/1", bus.out_valid, bus.in_ready); else n_pass++;
    n_total++; if (stall_cnt !== CNT_W'(m_cnt)) $display("FAIL skid_stall_cnt got=%0h exp=%0h", stall_cnt, m_cnt); else n_pass++;
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h40); bus.WB_in = 2'b11; bus.MEM_in = 3'b101;
    tick();
    drive(1'b1, 32'h50); bus.WB_in = 2'b11; bus.MEM_in = 3'b101;
    tick();
    flush = 1'b1;
    drive(1'b1, 32'h30);
    tick();
    flush = 1'b0;
    drive(1'b0, '0);
    n_total++; if (bus.out_valid !== 1'b0 || bus.WB_out !== '0 || bus.MEM_out !== '0)
      $display("FAIL flush_kill got=%0h/%0h/%0h exp=0/0/0", bus.out_valid, bus.WB_out, bus.MEM_out); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL flush_in_ready got=%0h exp=1", bus.in_ready); else n_pass++;
    n_total++; if (bus.ALU_out !== 32'h40) $display("FAIL flush_payload_kept got=%0h exp=40", bus.ALU_out); else n_pass++;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (bus.out_valid !== 1'b0 || bus.ALU_out !== 32'h40)
        $display("FAIL flush_no_c got=%0h/%0h exp=0/40", bus.out_valid, bus.ALU_out); else n_pass++;
    end
    // Flush with only MAIN held: the accepted-looking input must still be dropped.
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h60);
    tick();
    flush = 1'b1;
    drive(1'b1, 32'h31);
    tick();
    flush = 1'b0;
    drive(1'b0, '0);
    tick();
    n_total++; if (bus.out_valid !== 1'b0 || bus.ALU_out !== 32'h60)
      $display("FAIL flush_drop_input got=%0h/%0h exp=0/60", bus.out_valid, bus.ALU_out); else n_pass++;
  endtask

  task automatic test_stall_counter();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h77);
    tick();
    drive(1'b0, '0);
    for (int i = 0; i < 20; i++) begin
      tick();
      n_total++; if (stall_cnt !== CNT_W'(m_cnt))
        $display("FAIL stall_step%0d got=%0h exp=%0h", i, stall_cnt, m_cnt); else n_pass++;
    end
    tick();
    n_total++; if (stall_cnt !== CNT_W'(15)) $display("FAIL stall_saturate got=%0h exp=f", stall_cnt); else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_total++; if (stall_cnt !== '0 || bus.out_valid !== 1'b0)
      $display("FAIL stall_reset got=%0h/%0h exp=0/0", stall_cnt, bus.out_valid); else n_pass++;
  endtask

  task automatic test_bubble_gating();
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h99); bus.WB_in = 2'b01; bus.MEM_in = 3'b010;
    tick();
    n_total++; if (bus.WB_out !== 2'b01 || bus.MEM_out !== 3'b010)
      $display("FAIL bubble_valid_ctrl got=%0h/%0h exp=1/2", bus.WB_out, bus.MEM_out); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, XLEN'($urandom));
      bus.WB_in     = 2'b11;
      bus.MEM_in    = 3'b111;
      bus.out_ready = 1'($urandom);
      tick();
      n_total++; if (bus.WB_out !== '0 || bus.MEM_out !== '0)
        $display("FAIL bubble_gate got=%0h/%0h exp=0/0", bus.WB_out, bus.MEM_out); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [XLEN-1:0] tag;
    tag = 32'h1000;
    for (int i = 0; i < 10000; i++) begin
      reset = ($urandom_range(0, 999) == 0);
      flush = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 99) < 60, tag);
      bus.out_ready = ($urandom_range(0, 99) < 55);
      tag = tag + XLEN'(1);
      tick();
      n_total++; if (dut_out() !== m_out())
        $display("FAIL random_cycle%0d got=%0h exp=%0h", i, dut_out(), m_out()); else n_pass++;
    end
    reset = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    flush         = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, '0);
    shown = '0;
    m_cnt = 0;
    test_reset();
    test_streaming();
    test_skid();
    test_flush();
    test_stall_counter();
    test_bubble_gating();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
